// File: rtl/pedestrian_monitor.sv
// Passive safety checker beside the pedestrian traffic-light controller: follows the lamp phase
// sequence, latches the first fault with its cause code, and counts completed light cycles.
module pedestrian_monitor #(
  parameter int unsigned TIMER_SCALE = 16000000,
  parameter int unsigned TOL         = 16
) (
  input  logic        pin3_clk_16mhz,
  input  logic        pin9_rst,
  input  logic        pin4_green,
  input  logic        pin5_yellow,
  input  logic        pin6_red,
  input  logic        pin7_ped_green,
  input  logic        pin8_ped_red,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [2:0]  phase,
  output logic [15:0] cycles
);

  typedef enum logic [2:0] {
    S_SYNC     = 3'd0,
    S_GREEN    = 3'd1,
    S_YELLOW   = 3'd2,
    S_RED      = 3'd3,
    S_PEDGREEN = 3'd4,
    S_PEDRED   = 3'd5,
    S_FAULT    = 3'd7
  } state_t;

  localparam logic [4:0] PAT_GREEN    = 5'b10001;
  localparam logic [4:0] PAT_YELLOW   = 5'b01001;
  localparam logic [4:0] PAT_REDP     = 5'b00101;
  localparam logic [4:0] PAT_PEDGREEN = 5'b00110;
  localparam logic [4:0] PAT_OFF      = 5'b00000;
  localparam logic [4:0] PAT_PRE      = 5'b00001;

  localparam logic [31:0] EXP_10S = 32'd10 * 32'(TIMER_SCALE) + 32'd1;
  localparam logic [31:0] EXP_5S  = 32'd5 * 32'(TIMER_SCALE) + 32'd1;
  localparam logic [31:0] TOL_32  = 32'(TOL);
  localparam logic [29:0] DUR_MAX = 30'h3fff_ffff;

  localparam logic [2:0] C_NONE     = 3'd0;
  localparam logic [2:0] C_ILLEGAL  = 3'd1;
  localparam logic [2:0] C_ORDER    = 3'd2;
  localparam logic [2:0] C_SHORT    = 3'd3;
  localparam logic [2:0] C_LONG     = 3'd4;
  localparam logic [2:0] C_CONFLICT = 3'd5;

  state_t      state, state_nx;
  logic [4:0]  prev, prev_nx;
  logic [29:0] dur, dur_nx;
  logic [15:0] cycles_nx;
  logic        fault_nx;
  logic [2:0]  fault_code_nx;

  logic [4:0]  lamps;
  logic        change, checked, conflict, legal;
  logic [31:0] exp_cur, dur_32;
  logic [4:0]  succ_pat;
  state_t      succ_state;
  logic [2:0]  cause;

  assign lamps  = {pin4_green, pin5_yellow, pin6_red, pin7_ped_green, pin8_ped_red};
  assign phase  = state;
  assign dur_32 = {2'b00, dur};

  // Expected successor and nominal duration of the current phase
  always_comb begin
    exp_cur    = 32'd0;
    succ_pat   = PAT_GREEN;
    succ_state = S_GREEN;
    checked    = 1'b1;
    case (state)
      S_GREEN:    begin exp_cur = EXP_10S; succ_pat = PAT_YELLOW;   succ_state = S_YELLOW;   end
      S_YELLOW:   begin exp_cur = EXP_5S;  succ_pat = PAT_REDP;     succ_state = S_RED;      end
      S_RED:      begin exp_cur = EXP_5S;  succ_pat = PAT_PEDGREEN; succ_state = S_PEDGREEN; end
      S_PEDGREEN: begin exp_cur = EXP_10S; succ_pat = PAT_REDP;     succ_state = S_PEDRED;   end
      S_PEDRED:   begin exp_cur = EXP_5S;  succ_pat = PAT_GREEN;    succ_state = S_GREEN;    end
      default:    begin checked = 1'b0; end
    endcase
  end

  // Fault cause evaluation, highest priority first
  always_comb begin
    cause    = C_NONE;
    change   = (lamps != prev);
    conflict = pin7_ped_green & (pin4_green | pin5_yellow | ~pin6_red);
    legal    = (lamps == PAT_GREEN) || (lamps == PAT_YELLOW) ||
               (lamps == PAT_REDP)  || (lamps == PAT_PEDGREEN) ||
               ((state == S_SYNC) && ((lamps == PAT_OFF) || (lamps == PAT_PRE)));
    if (conflict) begin
      cause = C_CONFLICT;
    end else if (!legal) begin
      cause = C_ILLEGAL;
    end else if (checked && change && (lamps != succ_pat)) begin
      cause = C_ORDER;
    end else if (checked && change && (dur_32 < exp_cur - TOL_32)) begin
      cause = C_SHORT;
    end else if (checked && !change && (dur_32 >= exp_cur + TOL_32)) begin
      cause = C_LONG;
    end else begin
      cause = C_NONE;
    end
  end

  // Next-state: phase tracking, run-length counter, cycle counter; FAULT freezes everything
  always_comb begin
    state_nx      = state;
    prev_nx       = prev;
    dur_nx        = dur;
    cycles_nx     = cycles;
    fault_nx      = fault;
    fault_code_nx = fault_code;
    if (state != S_FAULT) begin
      prev_nx = lamps;
      if (change) begin
        dur_nx = 30'd1;
      end else if (dur != DUR_MAX) begin
        dur_nx = dur + 30'd1;
      end else begin
        dur_nx = dur;
      end
      if (cause != C_NONE) begin
        state_nx      = S_FAULT;
        fault_nx      = 1'b1;
        fault_code_nx = cause;
      end else if (change && (state == S_SYNC)) begin
        state_nx = (lamps == PAT_GREEN) ? S_GREEN : S_SYNC;
      end else if (change && checked) begin
        state_nx = succ_state;
        // A completed lap is counted as PEDRED hands back to GREEN
        if (state == S_PEDRED) begin
          cycles_nx = cycles + 16'd1;
        end else begin
          cycles_nx = cycles;
        end
      end else begin
        state_nx = state;
      end
    end else begin
      state_nx = S_FAULT;
    end
  end

  // State and output registers
  always_ff @(posedge pin3_clk_16mhz or posedge pin9_rst) begin
    if (pin9_rst) begin
      state      <= S_SYNC;
      prev       <= 5'b00000;
      dur        <= 30'd0;
      cycles     <= 16'd0;
      fault      <= 1'b0;
      fault_code <= 3'd0;
    end else begin
      state      <= state_nx;
      prev       <= prev_nx;
      dur        <= dur_nx;
      cycles     <= cycles_nx;
      fault      <= fault_nx;
      fault_code <= fault_code_nx;
    end
  end

endmodule

// File: tb/tb_pedestrian_monitor.sv
// Self-checking bench for pedestrian_monitor: directed scenarios plus randomized lamp runs,
// compared each cycle against a phase-table reference model.
`timescale 1ns/1ps
module tb_pedestrian_monitor;
  localparam int TS = 4;
  localparam int TL = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  lamps = 5'b00000;
  logic        fault;
  logic [2:0]  fault_code;
  logic [2:0]  phase;
  logic [15:0] cycles;

  pedestrian_monitor #(.TIMER_SCALE(TS), .TOL(TL)) dut (
    .pin3_clk_16mhz (clk),
    .pin9_rst       (rst),
    .pin4_green     (lamps[4]),
    .pin5_yellow    (lamps[3]),
    .pin6_red       (lamps[2]),
    .pin7_ped_green (lamps[1]),
    .pin8_ped_red   (lamps[0]),
    .fault          (fault),
    .fault_code     (fault_code),
    .phase          (phase),
    .cycles         (cycles)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] G   = 5'b10001;
  localparam logic [4:0] Y   = 5'b01001;
  localparam logic [4:0] R   = 5'b00101;
  localparam logic [4:0] PG  = 5'b00110;
  localparam logic [4:0] OFF = 5'b00000;
  localparam logic [4:0] PRE = 5'b00001;

  int tests = 0;
  int fails = 0;

  // Reference model: phase index 1..5 into the lamp sequence table, 0 = sync, 7 = fault
  logic [4:0] seq_pat [1:5];
  int         nom     [1:5];
  int         m_ph, m_run, m_code, m_cycles;
  logic [4:0] m_last;
  bit         m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_run = 0; m_code = 0; m_cycles = 0; m_last = 5'b00000; m_fault = 1'b0;
  endtask

  task automatic model_step(input logic [4:0] p);
    bit chg;
    bit is_phase;
    int code;
    int nxt;
    if (m_ph == 7) return;
    chg = (p != m_last);
    is_phase = (p == G) || (p == Y) || (p == R) || (p == PG);
    nxt = (m_ph % 5) + 1;
    code = 0;
    if (p[1] && (p[4] || p[3] || !p[2])) code = 5;
    else if (!(is_phase || (m_ph == 0 && (p == OFF || p == PRE)))) code = 1;
    else if (m_ph != 0 && chg && p != seq_pat[nxt]) code = 2;
    else if (m_ph != 0 && chg && m_run < nom[m_ph] - TL) code = 3;
    else if (m_ph != 0 && !chg && m_run >= nom[m_ph] + TL) code = 4;
    if (code != 0) begin
      m_ph = 7; m_code = code; m_fault = 1'b1;
      return;
    end
    if (chg) begin
      if (m_ph == 0) begin
        if (p == G) m_ph = 1;
      end else begin
        if (m_ph == 5) m_cycles = (m_cycles + 1) % 65536;
        m_ph = nxt;
      end
      m_run = 1;
    end else begin
      m_run++;
    end
    m_last = p;
  endtask

  task automatic compare_all();
    check("fault", 32'(fault), 32'(m_fault));
    check("fault_code", 32'(fault_code), 32'(m_code));
    check("phase", 32'(phase), 32'(m_ph));
    check("cycles", 32'(cycles), 32'(m_cycles));
  endtask

  task automatic step(input logic [4:0] p);
    lamps = p;
    @(posedge clk);
    model_step(p);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [4:0] p, input int n);
    for (int i = 0; i < n; i++) step(p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic full_cycle();
    hold(G, 41); hold(Y, 21); hold(R, 21); hold(PG, 41); hold(R, 21);
  endtask

  initial begin
    logic [4:0] p;
    int len;
    int gi;
    int roll;
    seq_pat[1] = G; seq_pat[2] = Y; seq_pat[3] = R; seq_pat[4] = PG; seq_pat[5] = R;
    nom[1] = 10 * TS + 1; nom[2] = 5 * TS + 1; nom[3] = 5 * TS + 1;
    nom[4] = 10 * TS + 1; nom[5] = 5 * TS + 1;

    #2;
    do_reset();
    check("reset_phase", 32'(phase), 32'd0);

    // Normal run: OFF -> PRE -> three full cycles -> GREEN
    hold(OFF, 3); hold(PRE, 3);
    full_cycle(); full_cycle(); full_cycle();
    step(G);
    check("normal_cycles", 32'(cycles), 32'd3);
    check("normal_fault", 32'(fault), 32'd0);
    check("normal_phase", 32'(phase), 32'd1);

    // Conflict: pedestrian green raised during GREEN
    hold(G, 4);
    step(5'b10011);
    check("conflict_code", 32'(fault_code), 32'd5);
    check("conflict_phase", 32'(phase), 32'd7);
    hold(G, 3);

    // Reset during FAULT, release mid-YELLOW, resync at next GREEN
    lamps = Y;
    do_reset();
    check("rst_fault", 32'(fault), 32'd0);
    hold(Y, 10); hold(R, 21); hold(PG, 41); hold(R, 21);
    check("resync_phase", 32'(phase), 32'd0);
    step(G);
    check("resync_green", 32'(phase), 32'd1);

    // Short yellow
    hold(G, 40); hold(Y, 19);
    step(R);
    check("short_code", 32'(fault_code), 32'd3);

    // 42-cycle GREEN passes; 43 samples fault LONG
    do_reset();
    hold(PRE, 2); hold(G, 42); hold(Y, 21);
    check("green42_ok", 32'(fault), 32'd0);
    do_reset();
    hold(PRE, 2); hold(G, 42);
    step(G);
    check("long_code", 32'(fault_code), 32'd4);

    // Skipped yellow
    do_reset();
    hold(PRE, 2); hold(G, 41);
    step(R);
    check("order_code", 32'(fault_code), 32'd2);
    check("order_cycles", 32'(cycles), 32'd0);

    // OFF outside sync
    do_reset();
    hold(PRE, 2); hold(G, 41);
    step(OFF);
    check("illegal_code", 32'(fault_code), 32'd1);

    // Randomized lamp runs around the nominal schedule
    for (int r = 0; r < 8; r++) begin
      do_reset();
      hold(PRE, 2);
      gi = 1;
      for (int s = 0; s < 12 && m_ph != 7; s++) begin
        p = seq_pat[gi];
        len = nom[gi];
        roll = int'($urandom_range(0, 99));
        if (roll < 6) p = 5'($urandom_range(0, 31));
        roll = int'($urandom_range(0, 99));
        if (roll < 75) len = len + int'($urandom_range(0, 2)) - 1;
        else if (roll < 90) len = len + (($urandom_range(0, 1) == 0) ? -2 : 2);
        else len = int'($urandom_range(1, 5));
        hold(p, len);
        gi = (gi % 5) + 1;
      end
      hold(seq_pat[gi], 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pedestrian_monitor.md
# pedestrian_monitor

Passive safety checker for the pedestrian traffic-light controller. Sits beside the controller in the same 16 MHz domain. Samples the five lamp drive signals and tracks the expected phase sequence GREEN→YELLOW→RED→PEDGREEN→PEDRED→GREEN. Latches a sticky fault with a cause code on any conflicting lamp pattern, out-of-order phase, or phase-duration violation, and counts completed light cycles.

## Interface
- TIMER_SCALE, 16000000: clock cycles per second; must match the controller.
- TOL, 16: allowed deviation, in cycles, from each phase's nominal duration.
- pin3_clk_16mhz  in  1  system clock; all logic on the rising edge.
- pin9_rst  in  1  reset; asynchronous, active-high.
- pin4_green, pin5_yellow, pin6_red, pin7_ped_green, pin8_ped_red  in  1 each  lamp signals.
  - Lamps are named g, y, r, pg, pr below.
  - Synchronous to pin3_clk_16mhz; no synchronizer.
- fault  out  1  sticky fault flag.
- fault_code  out  3  cause of the first fault; 0 when no fault.
- phase  out  3  tracked phase: 0 SYNC, 1 GREEN, 2 YELLOW, 3 RED, 4 PEDGREEN, 5 PEDRED, 7 FAULT.
- cycles  out  16  completed light cycles; wraps at 65535→0.

## Operation
- **Patterns** are written (g,y,r,pg,pr):
  - GREEN = 10001
  - YELLOW = 01001
  - REDP = 00101, shared by the RED and PEDRED phases; the phase is told apart by history.
  - PEDGREEN = 00110
  - OFF = 00000, PRE = 00001; legal in SYNC only.
- **Nominal durations**, EXP(p) = secs × TIMER_SCALE + 1 cycles:
  - GREEN 10 s, YELLOW 5 s, RED 5 s, PEDGREEN 10 s, PEDRED 5 s.
  - Compute in 32 bits.
- **Registers:**
  - prev, 5 bits: previous sample.
  - dur, 30 bits: number of consecutive edges at which the current pattern was sampled. Saturates at 2^30−1.
- **Change edge:** an edge where the inputs differ from prev. On a change edge dur loads 1; on any other edge dur increments.
- **Fault causes**, highest priority first:
  - 5 CONFLICT: pg & (g | y | ~r).
  - 1 ILLEGAL: a pattern not in the set legal for the current state.
  - 2 ORDER: a change edge where the new pattern is not the expected successor.
  - 3 SHORT: a change edge where dur < EXP(cur) − TOL.
  - 4 LONG: a non-change edge in a checked phase where dur ≥ EXP(cur) + TOL.
- **SYNC:**
  - Entered on reset.
  - All five phase patterns plus OFF and PRE are legal; no order or duration checks.
  - CONFLICT and ILLEGAL are still checked.
  - Leaves to GREEN on a change edge whose new pattern is GREEN.
  - Monitor reset mid-operation therefore resynchronises at the controller's next GREEN.
- **Checked transitions**, each on a change edge with a legal duration:
  - GREEN → YELLOW (pattern YELLOW)
  - YELLOW → RED (REDP)
  - RED → PEDGREEN (PEDGREEN)
  - PEDGREEN → PEDRED (REDP)
  - PEDRED → GREEN (GREEN); cycles increments on this transition.
- **FAULT:**
  - On any cause: fault=1, fault_code=cause, phase=7.
  - Terminal: inputs are ignored, cycles freezes, and only reset exits.
  - The first fault wins; later violations do not overwrite fault_code.
- **Reset values:** fault=0, fault_code=0, phase=0 (SYNC), cycles=0, prev=00000, dur=0.

## Timing
- Outputs are registered. The edge that samples the offending pattern sets fault, so fault is visible 1 cycle after the pattern is presented.
- phase updates on the change edge that detects the transition, i.e. 1 cycle after the lamps change.
- LONG fires on the edge that would be the (EXP+TOL+1)th sample of a pattern.
- Simultaneous causes: only the highest-priority code is reported.
- Reset asserted mid-phase or mid-fault: all state clears immediately (asynchronously).
- On reset release: monitor is in SYNC and ignores everything until the next change into GREEN.

## Test plan
- **Normal run:** drive the real controller with TIMER_SCALE=4 and a monitor with TIMER_SCALE=4, TOL=1 for 3 full cycles.
  - fault stays 0; cycles=3.
  - phase steps 0→1→2→3→4→5→1.
  - GREEN measured at 41 cycles, YELLOW at 21.
- **Conflict:** in GREEN, raise pg for 1 cycle → next cycle fault=1, fault_code=5, phase=7.
- **Short and long yellow** (TIMER_SCALE=4, TOL=1):
  - YELLOW held 19 cycles, then REDP → fault_code=3 on the change edge.
  - GREEN held 43 cycles → fault_code=4 on the 43rd sampling edge (dur already 42); 42 cycles passes.
- **Skipped phase:** after a legal GREEN (41 cycles), go directly to REDP → fault_code=2; cycles unchanged.
- **Reset/resync:**
  - Assert pin9_rst while in FAULT → all outputs 0 asynchronously.
  - Release mid-YELLOW → phase stays 0 through YELLOW/RED/PEDGREEN/PEDRED, enters 1 at the next GREEN, and no fault is raised.
- **SYNC illegal:** after a legal GREEN (41 cycles), present OFF → fault_code=1.
  - In SYNC, OFF→PRE→GREEN raises no fault.
